mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single physical memory port (the DPI `pmem` bridge) between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). It sequences one outstanding transaction at a time, steers the response back to its owner, and discards fetch responses killed by a pipeline redirect (`control_rest`). It sits between `if_stage`/`mem_stage` and the memory wrapper.

## Interface
- `ADDR_W`, 64, address width (matches `CPU_WIDTH`)
- `DATA_W`, 64, memory data width
- `STARVE_MAX`, 4, consecutive LSU grants tolerated while IF waits (guard only)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `if_req_valid` in 1, `if_req_ready` out 1, `if_addr` in ADDR_W: fetch request
- `if_kill` in 1: redirect; cancels pending or in-flight fetch
- `if_rsp_valid` out 1, `if_inst` out 32: fetched instruction (`mem_rdata[31:0]`)
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_addr` in ADDR_W, `lsu_we` in 1, `lsu_wdata` in DATA_W, `lsu_wmask` in 8
- `lsu_rsp_valid` out 1, `lsu_rdata` out DATA_W: load data or store ack
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_addr` out ADDR_W, `mem_we` out 1, `mem_wdata` out DATA_W, `mem_wmask` out 8
- `mem_rsp_valid` in 1, `mem_rdata` in DATA_W
- `busy` out 1: transaction in flight (state != IDLE)

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_LSU. Reset → IDLE.
- IDLE: select winner; drive `mem_*` combinationally from winner; `mem_req_valid` = winner valid. Winner's `*_req_ready` = `mem_req_ready`; loser's ready = 0.
- Priority: LSU over IF (older instruction). IF request masked while `if_kill`=1.
- Handshake fire (`mem_req_valid & mem_req_ready`) → WAIT_IF or WAIT_LSU next cycle. For IF, `if_we`=0, `mem_wmask`=0.
- WAIT_x: all `*_req_ready`=0, `mem_req_valid`=0. On `mem_rsp_valid`: owner `*_rsp_valid`=1 that cycle, data passthrough; next state IDLE.
- Kill: `if_kill` in WAIT_IF (or in the fire cycle of an IF grant) sets `kill_q`; matching response suppressed (`if_rsp_valid`=0), FSM still returns to IDLE. `kill_q` clears on return to IDLE. `if_kill` never affects LSU transactions.
- `mem_rsp_valid` in IDLE is ignored.
- Stores receive a response (ack); `lsu_rdata` content undefined for stores.

## Timing
- Reset values: state IDLE; `if_req_ready`, `lsu_req_ready`, `mem_req_valid`, `if_rsp_valid`, `lsu_rsp_valid`, `busy` = 0; `kill_q`=0; starve count 0. Data outputs are passthroughs, not reset.
- Request→memory: 0 cycles (combinational in IDLE). Memory response→owner: 0 cycles.
- Minimum occupancy 2 cycles per transaction (accept cycle + ≥1 response cycle); next grant earliest the cycle after the response.
- Simultaneous IF+LSU valid in IDLE: LSU wins; IF held, `if_req_ready`=0.
- `rst` mid-transaction: FSM to IDLE, flags cleared; late memory response ignored.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: counter increments on each LSU grant while `if_req_valid`=1; at `STARVE_MAX` the next arbitration gives IF priority; counter clears on IF grant or on an LSU grant with `if_req_valid`=0. Counter saturates at `STARVE_MAX`.
- Not defined: strict LSU priority, no counter logic.

## Structure
- FSM state encodings and `STARVE_MAX` default in `rvseed_defines.v`; widths from `CPU_WIDTH`.
- Single module; no sub-module (starve counter inline).

## Test plan
- IF only, addr 0x8000_0000, memory 1-cycle latency, rdata 0x00000413 → `if_rsp_valid` 1 cycle after fire, `if_inst`=0x00000413, `busy` high 1 cycle.
- IF and LSU load (0x8000_1000) valid same cycle → LSU fires first, IF fires cycle after LSU response; both responses routed correctly.
- Store addr 0x8000_2000, wdata 0xDEADBEEF, wmask 0x0F → `mem_we`=1, `mem_wmask`=0x0F, `lsu_rsp_valid` on ack, `if_rsp_valid` stays 0.
- IF fired, `if_kill` next cycle, response after 3 cycles → no `if_rsp_valid`; new IF at 0x8000_0100 accepted cycle after response.
- Guard on, LSU valid continuously, IF valid, `STARVE_MAX`=4 → IF granted after 4th LSU response; guard off → IF never granted while LSU valid.
- `rst` asserted in WAIT_LSU, memory responds after reset released → `lsu_rsp_valid` stays 0, FSM IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_LSU = 2'd2
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned INST_W         = 32;
    localparam int unsigned WMASK_W        = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (IF) and load/store (LSU).
// Optional IF anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [ADDR_W-1:0]  if_addr,
    input  logic               if_kill,
    output logic               if_rsp_valid,
    output logic [INST_W-1:0]  if_inst,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic               lsu_we,
    input  logic [DATA_W-1:0]  lsu_wdata,
    input  logic [WMASK_W-1:0] lsu_wmask,
    output logic               lsu_rsp_valid,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_rsp_valid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               busy
);

    arb_state_e state_reg, state_next;
    logic       kill_reg, kill_next;
    logic       if_cand;
    logic       grant_if;
    logic       grant_lsu;
    logic       if_boost;

    // A fetch being redirected this cycle is not worth starting.
    assign if_cand = if_req_valid & ~if_kill;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_reg, starve_next;

    assign if_boost = (starve_reg >= CNT_W'(STARVE_MAX)) & if_cand;

    always_comb begin
        starve_next = starve_reg;
        if (state_reg == IDLE && mem_req_ready) begin
            if (grant_if) begin
                starve_next = '0;
            end else if (grant_lsu) begin
                if (!if_req_valid) begin
                    starve_next = '0;
                end else if (starve_reg < CNT_W'(STARVE_MAX)) begin
                    starve_next = starve_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    assign if_boost = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        kill_next     = kill_reg;
        grant_if      = 1'b0;
        grant_lsu     = 1'b0;
        if_req_ready  = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_addr      = lsu_addr;
        mem_we        = lsu_we;
        mem_wdata     = lsu_wdata;
        mem_wmask     = lsu_wmask;

        case (state_reg)
            IDLE: begin
                kill_next = 1'b0;
                // LSU belongs to an older instruction, so it normally goes first.
                if (lsu_req_valid && !if_boost) begin
                    grant_lsu = 1'b1;
                end else if (if_cand) begin
                    grant_if = 1'b1;
                end
                mem_req_valid = grant_lsu | grant_if;
                lsu_req_ready = grant_lsu & mem_req_ready;
                if_req_ready  = grant_if & mem_req_ready;
                if (grant_if) begin
                    mem_addr  = if_addr;
                    mem_we    = 1'b0;
                    mem_wdata = '0;
                    mem_wmask = '0;
                end
                if (grant_lsu && mem_req_ready) begin
                    state_next = WAIT_LSU;
                end else if (grant_if && mem_req_ready) begin
                    state_next = WAIT_IF;
                end
            end
            WAIT_IF: begin
                if (if_kill) begin
                    kill_next = 1'b1;
                end
                if (mem_rsp_valid) begin
                    if_rsp_valid = ~(kill_reg | if_kill);
                    kill_next    = 1'b0;
                    state_next   = IDLE;
                end
            end
            WAIT_LSU: begin
                if (mem_rsp_valid) begin
                    lsu_rsp_valid = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                kill_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
        end
    end

    assign if_inst   = mem_rdata[INST_W-1:0];
    assign lsu_rdata = mem_rdata;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued at request time, checked on arrival.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid, if_req_ready, if_kill, if_rsp_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_inst;
    logic              lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]        lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [7:0]        mem_wmask;
    logic              busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_kill(if_kill), .if_rsp_valid(if_rsp_valid), .if_inst(if_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        is_store;
    } lsu_exp_t;

    int          checks = 0;
    int          failures = 0;
    int          mem_lat = 1;
    int          mm_cnt = 0;
    logic [63:0] mm_addr = '0;
    lsu_exp_t    lsu_q[$];
    logic [31:0] if_q[$];

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0000_0000_0413;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    // Memory model: captures a fired request mid-cycle, answers mem_lat cycles later.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        mem_req_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                mm_cnt  = mem_lat;
                mm_addr = mem_addr;
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (mm_cnt > 0) begin
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = mem_data(mm_addr);
                end
            end
        end
    end

    // Response scoreboard.
    initial begin
        lsu_exp_t    le;
        logic [31:0] ie;
        forever begin
            @(negedge clk);
            if (if_rsp_valid === 1'b1) begin
                checks++;
                if (if_q.size() == 0) begin
                    failures++;
                    $display("FAIL if_rsp_unexpected: got inst=%h, required no response", if_inst);
                end else begin
                    ie = if_q.pop_front();
                    if (if_inst !== ie) begin
                        failures++;
                        $display("FAIL if_inst: got %h required %h", if_inst, ie);
                    end else $display("if  response inst=%h", if_inst);
                end
            end
            if (lsu_rsp_valid === 1'b1) begin
                checks++;
                if (lsu_q.size() == 0) begin
                    failures++;
                    $display("FAIL lsu_rsp_unexpected: got rdata=%h, required no response", lsu_rdata);
                end else begin
                    le = lsu_q.pop_front();
                    if (!le.is_store && lsu_rdata !== le.data) begin
                        failures++;
                        $display("FAIL lsu_rdata: got %h required %h", lsu_rdata, le.data);
                    end else $display("lsu response store=%0b rdata=%h", le.is_store, lsu_rdata);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (if_req_ready !== 1'b0) begin failures++; $display("FAIL reset_if_ready: got %b required 0", if_req_ready); end
        checks++; if (lsu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_lsu_ready: got %b required 0", lsu_req_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %b required 0", mem_req_valid); end
        checks++; if (if_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b/%b required 0/0", if_rsp_valid, lsu_rsp_valid); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b required 0", busy); end
        next_cycle();
    endtask

    task automatic test_if_only;
        mem_lat = 1;
        if_q.push_back(32'h0000_0413);
        if_addr = 64'h8000_0000;
        if_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || if_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL if_only_handshake: got mv=%b ir=%b lr=%b required 1 1 0", mem_req_valid, if_req_ready, lsu_req_ready); end
        checks++; if (mem_addr !== 64'h8000_0000) begin failures++; $display("FAIL if_only_addr: got %h required 80000000", mem_addr); end
        checks++; if (mem_we !== 1'b0 || mem_wmask !== 8'h00) begin failures++; $display("FAIL if_only_we_mask: got we=%b mask=%h required 0 00", mem_we, mem_wmask); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL if_only_busy: got %b required 1", busy); end
        checks++; if (if_rsp_valid !== 1'b1) begin failures++; $display("FAIL if_only_rsp_valid: got %b required 1", if_rsp_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL if_only_busy_drop: got %b required 0", busy); end
        next_cycle();
        checks++; if (if_q.size() != 0) begin failures++; $display("FAIL if_only_drain: got %0d pending required 0", if_q.size()); end
    endtask

    task automatic test_priority;
        mem_lat = 1;
        lsu_q.push_back('{data: mem_data(64'h8000_1000), is_store: 1'b0});
        if_q.push_back(mem_data(64'h8000_0004) & 64'hFFFF_FFFF);
        lsu_addr = 64'h8000_1000; lsu_we = 1'b0; lsu_req_valid = 1'b1;
        if_addr = 64'h8000_0004; if_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (lsu_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin failures++; $display("FAIL prio_winner: got lr=%b ir=%b required 1 0", lsu_req_ready, if_req_ready); end
        checks++; if (mem_addr !== 64'h8000_1000) begin failures++; $display("FAIL prio_lsu_addr: got %h required 80001000", mem_addr); end
        next_cycle();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (lsu_rsp_valid !== 1'b1 || if_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL prio_wait_lsu: got rsp=%b ir=%b mv=%b required 1 0 0", lsu_rsp_valid, if_req_ready, mem_req_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1 || mem_addr !== 64'h8000_0004) begin failures++; $display("FAIL prio_if_grant: got ir=%b addr=%h required 1 80000004", if_req_ready, mem_addr); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (if_rsp_valid !== 1'b1) begin failures++; $display("FAIL prio_if_rsp: got %b required 1", if_rsp_valid); end
        next_cycle();
        checks++; if (if_q.size() != 0 || lsu_q.size() != 0) begin failures++; $display("FAIL prio_drain: got if=%0d lsu=%0d required 0 0", if_q.size(), lsu_q.size()); end
    endtask

    task automatic test_store;
        mem_lat = 1;
        lsu_q.push_back('{data: 64'h0, is_store: 1'b1});
        lsu_addr = 64'h8000_2000; lsu_we = 1'b1; lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_wmask !== 8'h0F) begin failures++; $display("FAIL store_we_mask: got we=%b mask=%h required 1 0f", mem_we, mem_wmask); end
        checks++; if (mem_wdata !== 64'hDEAD_BEEF || mem_addr !== 64'h8000_2000) begin failures++; $display("FAIL store_data_addr: got %h@%h required deadbeef@80002000", mem_wdata, mem_addr); end
        next_cycle();
        lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_wmask = 8'h00;
        @(negedge clk);
        checks++; if (lsu_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin failures++; $display("FAIL store_ack: got lsu=%b if=%b required 1 0", lsu_rsp_valid, if_rsp_valid); end
        next_cycle();
        checks++; if (lsu_q.size() != 0) begin failures++; $display("FAIL store_drain: got %0d pending required 0", lsu_q.size()); end
    endtask

    task automatic test_kill;
        mem_lat = 3;
        if_addr = 64'h8000_0008; if_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1) begin failures++; $display("FAIL kill_fire: got %b required 1", if_req_ready); end
        next_cycle();
        if_req_valid = 1'b0; if_kill = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL kill_busy: got %b required 1", busy); end
        next_cycle();
        if_kill = 1'b0; mem_lat = 1;
        if_addr = 64'h8000_0100; if_req_valid = 1'b1;
        if_q.push_back(mem_data(64'h8000_0100) & 64'hFFFF_FFFF);
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b0) begin failures++; $display("FAIL kill_hold_ready: got %b required 0", if_req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0 || if_req_ready !== 1'b0) begin failures++; $display("FAIL kill_suppress: got mrsp=%b irsp=%b ir=%b required 1 0 0", mem_rsp_valid, if_rsp_valid, if_req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1 || mem_addr !== 64'h8000_0100) begin failures++; $display("FAIL kill_refetch: got ir=%b addr=%h required 1 80000100", if_req_ready, mem_addr); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (if_rsp_valid !== 1'b1) begin failures++; $display("FAIL kill_refetch_rsp: got %b required 1", if_rsp_valid); end
        next_cycle();
        checks++; if (if_q.size() != 0) begin failures++; $display("FAIL kill_drain: got %0d pending required 0", if_q.size()); end
    endtask

    task automatic test_starve;
        int lsu_fires = 0;
        int if_fire_at = -1;
        int exp_if_at;
        bit fired_lsu;
`ifdef ARB_STARVE_GUARD_EN
        exp_if_at = 4;
`else
        exp_if_at = -1;
`endif
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_lat = 1;
        lsu_addr = 64'h8000_3000; lsu_we = 1'b0; lsu_req_valid = 1'b1;
        if_addr = 64'h8000_0200; if_req_valid = 1'b1;
        for (int c = 0; c < 30 && if_fire_at < 0; c++) begin
            @(negedge clk);
            fired_lsu = 1'b0;
            if (lsu_req_valid && lsu_req_ready) begin
                lsu_q.push_back('{data: mem_data(lsu_addr), is_store: 1'b0});
                lsu_fires++;
                fired_lsu = 1'b1;
            end
            if (if_req_valid && if_req_ready) begin
                if_q.push_back(mem_data(if_addr) & 64'hFFFF_FFFF);
                if_fire_at = lsu_fires;
            end
            next_cycle();
            if (fired_lsu) lsu_addr = lsu_addr + 64'd8;
        end
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        checks++; if (if_fire_at != exp_if_at) begin failures++; $display("FAIL starve_if_grant: got IF after %0d LSU grants required %0d", if_fire_at, exp_if_at); end
        checks++; if (lsu_fires < 4) begin failures++; $display("FAIL starve_lsu_grants: got %0d required >=4", lsu_fires); end
        repeat (3) next_cycle();
        checks++; if (if_q.size() != 0 || lsu_q.size() != 0) begin failures++; $display("FAIL starve_drain: got if=%0d lsu=%0d required 0 0", if_q.size(), lsu_q.size()); end
    endtask

    task automatic test_reset_mid;
        mem_lat = 4;
        lsu_addr = 64'h8000_4000; lsu_we = 1'b0; lsu_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_fire: got %b required 1", lsu_req_ready); end
        next_cycle();
        lsu_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (lsu_rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_cycle%0d: got rsp=%b busy=%b required 0 0", c, lsu_rsp_valid, busy); end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = '0; if_kill = 1'b0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_we = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        test_reset();
        test_if_only();
        test_priority();
        test_store();
        test_kill();
        test_starve();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
